citron_bus_arbiter: RTL
=======================

Name: citron_bus_arbiter

Overview:
- Shares one Citron bus between NUM_REQ requesters, such as per-thread CPU ports or a debug loader, with round-robin fairness.
- Sits between the requesters and the peripheral fabric: UART, sim debug port at 0xFE/0xFF, timers.
- Holds a grant for one whole transaction. Completes unmatched accesses locally so a bad address cannot hang a requester.
- Drives the shared bus; peripherals' match/stall/readdata arrive already OR/muxed.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- TIMEOUT_CYCLES, 1024, stall cycles before forced completion. Used only with CITRON_ARB_TIMEOUT_EN.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous active-high reset.
- req_addr_i  in  8*NUM_REQ  per-requester Citron address; requester i at bits [8i+7:8i].
- req_rdy_i  in  NUM_REQ  per-requester transaction request.
- req_wr_i  in  NUM_REQ  per-requester write (1) / read (0).
- req_writedata_i  in  32*NUM_REQ  per-requester write data.
- req_readdata_o  out  32  read data, valid only in a requester's completion cycle.
- req_stall_o  out  NUM_REQ  per-requester stall.
- citron_addr_o  out  8  bus address.
- citron_rdy_o  out  1  bus request.
- citron_wr_o  out  1  bus write.
- citron_writedata_o  out  32  bus write data.
- citron_readdata_i  in  32  bus read data.
- citron_stall_i  in  1  bus stall.
- citron_match_i  in  1  some device decodes citron_addr_o.
- arb_err_o  out  1  one-cycle pulse on unmatched or timed-out completion.

Behaviour:
- Clock/reset: one clock, clk_i; reset rst_i is synchronous, active-high.
- Reset values: state=IDLE, grant=0, rr_ptr=0, timeout counter=0.
  - citron_rdy_o=0; citron_addr_o, citron_wr_o, citron_writedata_o=0.
  - arb_err_o=0, req_readdata_o=0.
  - req_stall_o=req_rdy_i, so every requester stalls during reset.
- States:
  - IDLE: bus outputs all 0.
    - If any req_rdy_i is set, pick the first set bit searching from rr_ptr upward with wrap.
    - Register the winner into grant and go to BUSY.
    - The arbitration cycle always stalls every requesting master.
  - BUSY: bus outputs = granted requester's addr/wr/writedata; citron_rdy_o=req_rdy_i[grant].
- Completion in BUSY (exactly one of the following applies):
  - Normal: req_rdy_i[grant] && citron_match_i && !citron_stall_i.
    - req_stall_o[grant]=0 and req_readdata_o=citron_readdata_i (combinational, same cycle).
    - Next: state IDLE, rr_ptr=(grant+1) mod NUM_REQ.
  - Unmatched: req_rdy_i[grant] && !citron_match_i.
    - Completes in the same cycle; citron_stall_i is ignored.
    - req_readdata_o=0; arb_err_o=1 for one cycle.
    - Next: state IDLE, rr_ptr advances as for a normal completion.
  - Abandon: !req_rdy_i[grant] (protocol violation).
    - Return to IDLE with no completion and no error; rr_ptr advances.
- Outside a completion cycle:
  - req_stall_o[i]=req_rdy_i[i].
  - req_readdata_o=0.
- Latency and throughput:
  - Minimum transaction is 2 cycles: arbitration, then data.
  - Peak throughput is one transaction per 2 cycles.
  - A device stall extends BUSY indefinitely unless the optional feature is enabled.
- Fairness:
  - A requester that completes gets lowest priority next round.
  - With all NUM_REQ requesting continuously, grants rotate 0,1,…,NUM_REQ-1,0.
- Simultaneous events: a new req_rdy_i in the completion cycle is not considered until the following IDLE cycle.
- Reset mid-BUSY: transaction dropped, no completion signalled, all state returns to reset values next cycle.

Optional Feature:
- Macro: CITRON_ARB_TIMEOUT_EN.
- When defined, a 16-bit counter:
  - clears on entry to BUSY;
  - increments each BUSY cycle with citron_stall_i=1 while matched.
- On reaching TIMEOUT_CYCLES-1 with the stall still asserted:
  - force completion: req_stall_o[grant]=0, req_readdata_o=32'hFFFF_FFFF, arb_err_o=1;
  - then state IDLE, rr_ptr advances.
- When undefined: no counter is present, stalls are honoured forever, and arb_err_o pulses only for unmatched accesses.

Decomposition:
- Package citron_pkg:
  - CITRON_ADDR_W=8, CITRON_DATA_W=32;
  - arbiter state enum {ARB_IDLE, ARB_BUSY};
  - TIMEOUT_READDATA=32'hFFFF_FFFF constant.
- Sub-module citron_rr_pick:
  - combinational rotating priority encoder (req vector, rr_ptr → winner index, any_valid);
  - reusable by other fabric arbiters.
- The state register, timeout counter and muxing stay in citron_bus_arbiter.

Test Plan:
- Single read: NUM_REQ=2, req0 rdy addr 0x10, device match, stall=0, readdata 0xDEADBEEF → citron_rdy_o at cycle 1, req_stall_o[0] low at cycle 1 with req_readdata_o=0xDEADBEEF; rr_ptr=1.
- Contention: req0 and req1 both hold rdy for 4 transactions → grant order 0,1,0,1; each completion 2 cycles apart; the non-granted requester's stall stays high.
- Device stall: req1 write addr 0xFF data 0x41000000, citron_stall_i high 3 cycles → citron_writedata_o stable 0x41000000 for 4 BUSY cycles; completion in 4th; no arb_err_o.
- Unmatched: req0 read addr 0x80, match=0, stall=1 → completes in first BUSY cycle, readdata 0, arb_err_o pulses once.
- Reset mid-BUSY: assert rst_i during stalled BUSY → next cycle citron_rdy_o=0, grant=0, rr_ptr=0, no completion seen by the requester.
- With CITRON_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8, stall held forever → forced completion after 8 BUSY cycles, readdata 0xFFFFFFFF, arb_err_o=1, next requester then granted.

Source files
------------

// File: rtl/citron_pkg.sv
// ---------------------------------------------------------------------------
// citron_pkg
//   Shared definitions for the Citron bus fabric: bus field widths, the bus
//   arbiter state encoding, and the read data returned on a forced
//   (timed-out) completion.
// ---------------------------------------------------------------------------
package citron_pkg;

    localparam int CITRON_ADDR_W = 8;
    localparam int CITRON_DATA_W = 32;

    // Read data handed back when a stalled transaction is forcibly completed.
    localparam logic [CITRON_DATA_W-1:0] TIMEOUT_READDATA = 32'hFFFF_FFFF;

    typedef enum logic {
        ARB_IDLE,
        ARB_BUSY
    } arb_state_t;

endpackage : citron_pkg

// File: rtl/citron_rr_pick.sv
// ---------------------------------------------------------------------------
// citron_rr_pick
//   Combinational rotating priority encoder. Searches req upward starting at
//   rr_ptr, wrapping at NUM_REQ-1, and returns the first set index.
//
// Ports:
//   req        in   NUM_REQ  request vector
//   rr_ptr     in   PTR_W    index holding highest priority this round
//   winner     out  PTR_W    index of the selected request (0 when none)
//   any_valid  out  1        at least one request bit is set
// ---------------------------------------------------------------------------
module citron_rr_pick #(
    parameter int NUM_REQ = 2,
    parameter int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   rr_ptr,
    output logic [PTR_W-1:0]   winner,
    output logic               any_valid
);

    always_comb begin
        // NOTE: every output gets a default before any branch, so no path
        // leaves a value unassigned and no latch is inferred.
        winner    = '0;
        any_valid = 1'b0;
        // Walk from the farthest offset down to offset 0 so the closest
        // requester to rr_ptr is the last (and therefore winning) assignment.
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            logic [PTR_W-1:0] idx;
            idx = PTR_W'((int'(rr_ptr) + k) % NUM_REQ);
            if (req[idx]) begin
                winner    = idx;
                any_valid = 1'b1;
            end
        end
    end

endmodule : citron_rr_pick

// File: rtl/citron_bus_arbiter.sv
// ---------------------------------------------------------------------------
// citron_bus_arbiter
//   Round-robin owner of the shared Citron bus. One requester is granted per
//   transaction; the grant is held until the transaction completes. Accesses
//   no device decodes are completed locally with an error pulse so a bad
//   address never hangs a requester.
//
//   Optional build macro CITRON_ARB_TIMEOUT_EN adds a stall watchdog that
//   forcibly completes a transaction stalled for TIMEOUT_CYCLES cycles.
//
// Ports:
//   clk_i               in   1            clock
//   rst_i               in   1            synchronous active-high reset
//   req_addr_i          in   8*NUM_REQ    requester addresses, i at [8i+7:8i]
//   req_rdy_i           in   NUM_REQ      requester transaction request
//   req_wr_i            in   NUM_REQ      requester write (1) / read (0)
//   req_writedata_i     in   32*NUM_REQ   requester write data
//   req_readdata_o      out  32           read data, valid in completion cycle
//   req_stall_o         out  NUM_REQ      per-requester stall
//   citron_addr_o       out  8            bus address
//   citron_rdy_o        out  1            bus request
//   citron_wr_o         out  1            bus write
//   citron_writedata_o  out  32           bus write data
//   citron_readdata_i   in   32           bus read data (already muxed)
//   citron_stall_i      in   1            bus stall (already ORed)
//   citron_match_i      in   1            some device decodes citron_addr_o
//   arb_err_o           out  1            pulse on unmatched/timed-out finish
// ---------------------------------------------------------------------------
module citron_bus_arbiter
    import citron_pkg::*;
#(
    parameter int NUM_REQ        = 2,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                               clk_i,
    input  logic                               rst_i,
    input  logic [CITRON_ADDR_W*NUM_REQ-1:0]   req_addr_i,
    input  logic [NUM_REQ-1:0]                 req_rdy_i,
    input  logic [NUM_REQ-1:0]                 req_wr_i,
    input  logic [CITRON_DATA_W*NUM_REQ-1:0]   req_writedata_i,
    output logic [CITRON_DATA_W-1:0]           req_readdata_o,
    output logic [NUM_REQ-1:0]                 req_stall_o,
    output logic [CITRON_ADDR_W-1:0]           citron_addr_o,
    output logic                               citron_rdy_o,
    output logic                               citron_wr_o,
    output logic [CITRON_DATA_W-1:0]           citron_writedata_o,
    input  logic [CITRON_DATA_W-1:0]           citron_readdata_i,
    input  logic                               citron_stall_i,
    input  logic                               citron_match_i,
    output logic                               arb_err_o
);

    localparam int PTR_W = $clog2(NUM_REQ);

    arb_state_t       state, state_nxt;
    logic [PTR_W-1:0] grant, grant_nxt;
    logic [PTR_W-1:0] rr_ptr, rr_ptr_nxt;
    logic [PTR_W-1:0] pick_idx;
    logic             pick_valid;
    logic [PTR_W-1:0] rr_adv;

    logic [CITRON_ADDR_W-1:0] sel_addr;
    logic [CITRON_DATA_W-1:0] sel_writedata;
    logic                     sel_rdy;
    logic                     sel_wr;
    logic                     timeout_hit;

    citron_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_pick (
        .req       (req_rdy_i),
        .rr_ptr    (rr_ptr),
        .winner    (pick_idx),
        .any_valid (pick_valid)
    );

    assign sel_addr      = req_addr_i[CITRON_ADDR_W*grant +: CITRON_ADDR_W];
    assign sel_writedata = req_writedata_i[CITRON_DATA_W*grant +: CITRON_DATA_W];
    assign sel_rdy       = req_rdy_i[grant];
    assign sel_wr        = req_wr_i[grant];

    // The requester just served drops to lowest priority.
    assign rr_adv = (grant == PTR_W'(NUM_REQ - 1)) ? '0 : grant + 1'b1;

`ifdef CITRON_ARB_TIMEOUT_EN
    logic [15:0] to_cnt;

    assign timeout_hit = (to_cnt == 16'(TIMEOUT_CYCLES - 1));

    // Held at zero while idle, which clears it on every entry to BUSY.
    always_ff @(posedge clk_i) begin
        if (rst_i || state == ARB_IDLE) begin
            to_cnt <= '0;
        end else if (sel_rdy && citron_match_i && citron_stall_i) begin
            to_cnt <= to_cnt + 16'd1;
        end
    end
`else
    assign timeout_hit = 1'b0;

    // TIMEOUT_CYCLES only matters in the watchdog build.
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
`endif

    // NOTE: state registers use non-blocking assignments so every flop
    // samples its pre-edge value regardless of statement order.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state  <= ARB_IDLE;
            grant  <= '0;
            rr_ptr <= '0;
        end else begin
            state  <= state_nxt;
            grant  <= grant_nxt;
            rr_ptr <= rr_ptr_nxt;
        end
    end

    always_comb begin
        state_nxt          = state;
        grant_nxt          = grant;
        rr_ptr_nxt         = rr_ptr;
        citron_addr_o      = '0;
        citron_rdy_o       = 1'b0;
        citron_wr_o        = 1'b0;
        citron_writedata_o = '0;
        req_stall_o        = req_rdy_i;
        req_readdata_o     = '0;
        arb_err_o          = 1'b0;

        // In reset every output holds its reset value, so a transaction in
        // flight is dropped without any completion being signalled.
        if (!rst_i) begin
            unique case (state)
                ARB_IDLE: begin
                    if (pick_valid) begin
                        grant_nxt = pick_idx;
                        state_nxt = ARB_BUSY;
                    end
                end
                ARB_BUSY: begin
                    citron_addr_o      = sel_addr;
                    citron_rdy_o       = sel_rdy;
                    citron_wr_o        = sel_wr;
                    citron_writedata_o = sel_writedata;
                    if (!sel_rdy) begin
                        // Requester withdrew: free the bus silently.
                        state_nxt  = ARB_IDLE;
                        rr_ptr_nxt = rr_adv;
                    end else if (!citron_match_i) begin
                        // Nobody decodes the address; device stall is moot.
                        req_stall_o[grant] = 1'b0;
                        arb_err_o          = 1'b1;
                        state_nxt          = ARB_IDLE;
                        rr_ptr_nxt         = rr_adv;
                    end else if (!citron_stall_i) begin
                        req_stall_o[grant] = 1'b0;
                        req_readdata_o     = citron_readdata_i;
                        state_nxt          = ARB_IDLE;
                        rr_ptr_nxt         = rr_adv;
                    end else if (timeout_hit) begin
                        req_stall_o[grant] = 1'b0;
                        req_readdata_o     = TIMEOUT_READDATA;
                        arb_err_o          = 1'b1;
                        state_nxt          = ARB_IDLE;
                        rr_ptr_nxt         = rr_adv;
                    end
                end
                default: state_nxt = ARB_IDLE;
            endcase
        end
    end

endmodule : citron_bus_arbiter
